multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle main controller that replaces the combinational single-cycle control_unit.
//  Moore FSM (one Mealy gate on mem_ready) sequences the shared cpumemory, ALU, register file and PC mux selects.
//  Supports R-type, lw, sw, beq, addi and j, and stalls on a memory ready handshake.
//  Also provides a retired-instruction counter and a sticky illegal-opcode flag.
// PARAMETERS
//  CNT_WIDTH  32  width of instr_count, which wraps modulo 2^CNT_WIDTH
// PORTS
//  clk           in   1   system clock; all state changes on posedge
//  rst           in   1   asynchronous, active-low reset
//  instr_op      in   6   opcode from the instruction register; stable from DECODE until the next FETCH
//  mem_ready     in   1   memory access complete this cycle
//  pc_write      out  1   unconditional PC load
//  pc_write_cond out  1   PC load gated by ALU zero (beq)
//  i_or_d        out  1   memory address select: 0 = PC, 1 = ALUOut
//  mem_read      out  1   memory read request
//  mem_write     out  1   memory write request
//  ir_write      out  1   instruction register load
//  mem_to_reg    out  1   write-data select: 0 = ALUOut, 1 = MDR
//  reg_dst       out  1   destination select: 0 = rt, 1 = rd
//  reg_write     out  1   register file write enable
//  alu_src_a     out  1   ALU A select: 0 = PC, 1 = rs data
//  alu_src_b     out  2   ALU B select: 00 = rt data, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
//  alu_op        out  2   to alu_control: 00 = add, 01 = sub, 10 = funct
//  pc_source     out  2   PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  state_out     out  4   current state encoding (debug)
//  illegal_op    out  1   sticky flag: an unsupported opcode was decoded
//  instr_count   out  CNT_WIDTH  count of retired instructions
// BEHAVIOUR
//  Opcodes: R = 6'h00, j = 6'h02, beq = 6'h04, addi = 6'h08, lw = 6'h23, sw = 6'h2B.
//  Reset (rst = 0, asynchronous) sets: state = START, instr_count = 0, illegal_op = 0.
//  In START every control output is 0, so all outputs are 0 during and right after reset.
//  Outputs decode the registered state. Any output not listed for a state is 0.
//  State transitions:
//   0  START:     -> FETCH
//   1  FETCH:     mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00
//                 ir_write = pc_write = mem_ready (Mealy gate)
//                 mem_ready = 1 -> DECODE; otherwise hold in FETCH
//   2  DECODE:    alu_src_a = 0, alu_src_b = 11, alu_op = 00
//                 lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX
//                 any other opcode -> FETCH and set illegal_op
//   3  MEM_ADDR:  alu_src_a = 1, alu_src_b = 10, alu_op = 00
//                 lw -> MEM_READ; sw -> MEM_WRITE
//   4  MEM_READ:  mem_read = 1, i_or_d = 1
//                 mem_ready = 1 -> MEM_WB; otherwise hold
//   5  MEM_WB:    reg_dst = 0, mem_to_reg = 1, reg_write = 1 -> FETCH (retire)
//   6  MEM_WRITE: mem_write = 1, i_or_d = 1
//                 mem_ready = 1 -> FETCH (retire); otherwise hold
//   7  EXEC:      alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> R_WB
//   8  R_WB:      reg_dst = 1, reg_write = 1 -> FETCH (retire)
//   9  BRANCH:    alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01 -> FETCH (retire)
//   10 JUMP:      pc_write = 1, pc_source = 10 -> FETCH (retire)
//   11 ADDI_EX:   alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> ADDI_WB
//   12 ADDI_WB:   reg_dst = 0, reg_write = 1 -> FETCH (retire)
//   13-15:        all outputs 0 -> START
//  Latency in cycles, with mem_ready held at 1:
//   R = 4, lw = 5, sw = 4, beq = 3, j = 3, addi = 4
//   each cycle with mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds 1
//  Stalls: mem_read/mem_write, i_or_d and the other outputs stay constant while waiting.
//   ir_write and pc_write stay 0 until mem_ready = 1.
//  instr_count: +1 on the clock edge that leaves a "(retire)" state.
//   Illegal opcodes do not count. Wraps from all-ones to 0 with no flag.
//  illegal_op: set on the edge that leaves DECODE with an illegal opcode. Cleared only by reset.
//  Reset mid-operation aborts immediately: state = START, all outputs 0, and no partial write is issued.
// TESTING
//  T1 Reset: rst = 0 for 3 cycles, then release
//     -> outputs all 0, state_out = 0; next cycle state_out = 1 with mem_read = 1
//  T2 R-type: instr_op = 00, mem_ready = 1
//     -> state_out sequence 1,2,7,8,1; reg_write = 1 and reg_dst = 1 only in state 8; instr_count = 1
//  T3 lw with stall: instr_op = 23, mem_ready = 0 for the first 2 cycles of MEM_READ
//     -> state 4 lasts 3 cycles with mem_read = i_or_d = 1; then state 5 with mem_to_reg = 1
//  T4 sw, beq, j back-to-back
//     -> mem_write = 1 only in state 6
//     -> pc_write_cond = 1 with pc_source = 01 in state 9
//     -> pc_write = 1 with pc_source = 10 in state 10
//     -> instr_count += 3
//  T5 Illegal opcode: instr_op = 3F
//     -> DECODE then FETCH; illegal_op = 1 and stays 1; instr_count unchanged; no reg_write or mem_write
//  T6 Reset and wrap: assert rst during MEM_READ
//     -> outputs 0 asynchronously, count = 0
//     with CNT_WIDTH = 4, run 16 R-types -> instr_count wraps from 15 to 0

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller: Moore FSM driving memory, ALU, register file and PC selects,
// with a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control_fsm #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           instr_op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state_out,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;

  typedef enum logic [3:0] {
    StStart    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExec     = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StAddiEx   = 4'd11,
    StAddiWb   = 4'd12
  } state_e;

  state_e                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   retire;
  logic                   op_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StStart;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign op_illegal = !(instr_op inside {OpR, OpJ, OpBeq, OpAddi, OpLw, OpSw});

  always_comb begin
    state_d = StStart;
    retire  = 1'b0;
    case (state_q)
      StStart:    state_d = StFetch;
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (instr_op)
          OpLw, OpSw: state_d = StMemAddr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = (instr_op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        state_d = mem_ready ? StFetch : StMemWrite;
        retire  = mem_ready;
      end
      StExec:     state_d = StRWb;
      StRWb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StAddiEx:   state_d = StAddiWb;
      default:    state_d = StStart;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | ((state_q == StDecode) & op_illegal);
    count_d   = retire ? count_q + CNT_WIDTH'(1) : count_q;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only once the fetch data is actually there
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode:   alu_src_b = 2'b11;
      StMemAddr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StAddiWb:   reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state_out   = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a 4-bit counter so the wrap is reachable.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_out;
  logic [3:0] instr_count;
  logic [15:0] ctrl;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control_fsm #(.CNT_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_op      (instr_op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state_out     (state_out),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // Bit order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  // reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [15:0] CFetch    = 16'h9410;
  localparam logic [15:0] CFetchStl = 16'h1010;
  localparam logic [15:0] CDecode   = 16'h0030;
  localparam logic [15:0] CAddr     = 16'h0060;
  localparam logic [15:0] CMemRd    = 16'h3000;
  localparam logic [15:0] CMemWb    = 16'h0280;
  localparam logic [15:0] CMemWr    = 16'h2800;
  localparam logic [15:0] CExec     = 16'h0048;
  localparam logic [15:0] CRWb      = 16'h0180;
  localparam logic [15:0] CBranch   = 16'h4045;
  localparam logic [15:0] CJump     = 16'h8002;
  localparam logic [15:0] CAddiWb   = 16'h0080;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check state plus the full control word.
  task automatic step(input string tag, input logic [3:0] st, input logic [15:0] c);
    @(negedge clk);
    chk({tag, ".state"}, {28'd0, state_out}, {28'd0, st});
    chk({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, c});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1 reset
    rst = 1'b0; instr_op = 6'h00; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.state", {28'd0, state_out}, 32'd0);
    chk("rst.ctrl", {16'd0, ctrl}, 32'd0);
    chk("rst.count", {28'd0, instr_count}, 32'd0);
    chk("rst.illegal", {31'd0, illegal_op}, 32'd0);
    rst = 1'b1;
    #1 chk("rel.state", {28'd0, state_out}, 32'd0);
    step("t1.fetch", 4'd1, CFetch);

    // T2 R-type
    step("r.dec", 4'd2, CDecode);
    step("r.exec", 4'd7, CExec);
    step("r.wb", 4'd8, CRWb);
    step("r.fetch", 4'd1, CFetch);
    chk("r.count", {28'd0, instr_count}, 32'd1);

    // T3 lw with two stall cycles in MEM_READ
    instr_op = 6'h23;
    step("lw.dec", 4'd2, CDecode);
    step("lw.addr", 4'd3, CAddr);
    mem_ready = 1'b0;
    step("lw.rd0", 4'd4, CMemRd);
    step("lw.rd1", 4'd4, CMemRd);
    step("lw.rd2", 4'd4, CMemRd);
    mem_ready = 1'b1;
    step("lw.wb", 4'd5, CMemWb);
    step("lw.fetch", 4'd1, CFetch);
    chk("lw.count", {28'd0, instr_count}, 32'd2);

    // T4 sw (after a one-cycle fetch stall), beq, j
    instr_op = 6'h2B;
    mem_ready = 1'b0;
    step("sw.fstall", 4'd1, CFetchStl);
    mem_ready = 1'b1;
    step("sw.dec", 4'd2, CDecode);
    step("sw.addr", 4'd3, CAddr);
    step("sw.wr", 4'd6, CMemWr);
    step("sw.fetch", 4'd1, CFetch);
    instr_op = 6'h04;
    step("beq.dec", 4'd2, CDecode);
    step("beq.br", 4'd9, CBranch);
    step("beq.fetch", 4'd1, CFetch);
    instr_op = 6'h02;
    step("j.dec", 4'd2, CDecode);
    step("j.jmp", 4'd10, CJump);
    step("j.fetch", 4'd1, CFetch);
    chk("t4.count", {28'd0, instr_count}, 32'd5);

    // T5 illegal opcode, twice, then addi
    instr_op = 6'h3F;
    chk("ill.pre", {31'd0, illegal_op}, 32'd0);
    step("ill.dec", 4'd2, CDecode);
    step("ill.fetch", 4'd1, CFetch);
    chk("ill.flag", {31'd0, illegal_op}, 32'd1);
    chk("ill.count", {28'd0, instr_count}, 32'd5);
    step("ill2.dec", 4'd2, CDecode);
    step("ill2.fetch", 4'd1, CFetch);
    instr_op = 6'h08;
    step("addi.dec", 4'd2, CDecode);
    step("addi.ex", 4'd11, CAddr);
    step("addi.wb", 4'd12, CAddiWb);
    step("addi.fetch", 4'd1, CFetch);
    chk("addi.count", {28'd0, instr_count}, 32'd6);
    chk("addi.flag", {31'd0, illegal_op}, 32'd1);

    // T6 asynchronous reset in the middle of a stalled MEM_READ
    instr_op = 6'h23;
    step("t6.dec", 4'd2, CDecode);
    mem_ready = 1'b0;
    step("t6.addr", 4'd3, CAddr);
    step("t6.rd", 4'd4, CMemRd);
    #2 rst = 1'b0;
    #1;
    chk("arst.state", {28'd0, state_out}, 32'd0);
    chk("arst.ctrl", {16'd0, ctrl}, 32'd0);
    chk("arst.count", {28'd0, instr_count}, 32'd0);
    chk("arst.illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    chk("arst.hold", {28'd0, state_out}, 32'd0);
    rst = 1'b1; instr_op = 6'h00; mem_ready = 1'b1;
    step("wrap.fetch", 4'd1, CFetch);
    for (int i = 0; i < 16; i++) begin
      step("wrap.dec", 4'd2, CDecode);
      step("wrap.exec", 4'd7, CExec);
      step("wrap.wb", 4'd8, CRWb);
      step("wrap.fetch", 4'd1, CFetch);
      chk("wrap.count", {28'd0, instr_count}, 32'((i + 1) % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
